// File: rtl/count_checker.sv
// Counter stream monitor: infers the count direction from sampled values,
// locks onto a consistent +/-1 step, and flags and counts each broken step.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no reference sample held yet
// S_SEEN   | reference held; accumulating same-direction steps toward lock
// S_LOCKED | direction established; every sample must equal expected
module count_checker #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8,
  parameter int LOCK_N    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_count,
  input  logic                 clear,
  output logic                 locked,
  output logic                 dir_up,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     expected
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEEN   = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  localparam logic [3:0]           LOCK_THR = 4'(LOCK_N);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     prev, prev_nxt;
  logic [3:0]           match_cnt, match_nxt;
  logic                 dir_nxt;
  logic                 err_event;
  logic                 locked_nxt, step_nxt;
  logic [ERR_CNT_W-1:0] err_nxt;
  logic [WIDTH-1:0]     step_up, step_dn;

  // Wrapping arithmetic makes max->0 a valid up step and 0->max a valid down step.
  assign step_up  = prev + 1'b1;
  assign step_dn  = prev - 1'b1;
  assign expected = dir_up ? step_up : step_dn;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      prev      <= '0;
      match_cnt <= '0;
      dir_up    <= 1'b1;
      locked    <= 1'b0;
      step_err  <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      prev      <= prev_nxt;
      match_cnt <= match_nxt;
      dir_up    <= dir_nxt;
      locked    <= locked_nxt;
      step_err  <= step_nxt;
      err_count <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    prev_nxt  = prev;
    match_nxt = match_cnt;
    dir_nxt   = dir_up;
    err_event = 1'b0;
    if (clear) begin
      state_nxt = S_IDLE;
      match_nxt = '0;
    end else if (in_valid) begin
      case (state)
        S_IDLE: begin
          prev_nxt  = in_count;
          state_nxt = S_SEEN;
        end
        S_SEEN: begin
          prev_nxt = in_count;
          if (in_count == step_up) begin
            if (dir_up && (match_cnt != 4'd0)) begin
              match_nxt = match_cnt + 4'd1;
            end else begin
              dir_nxt   = 1'b1;
              match_nxt = 4'd1;
            end
          end else if (in_count == step_dn) begin
            if (!dir_up && (match_cnt != 4'd0)) begin
              match_nxt = match_cnt + 4'd1;
            end else begin
              dir_nxt   = 1'b0;
              match_nxt = 4'd1;
            end
          end else begin
            match_nxt = '0;
          end
          if (match_nxt == LOCK_THR) state_nxt = S_LOCKED;
        end
        S_LOCKED: begin
          prev_nxt = in_count;
          if (in_count != expected) begin
            err_event = 1'b1;
            state_nxt = S_SEEN;
            match_nxt = '0;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    locked_nxt = (state_nxt == S_LOCKED);
    step_nxt   = err_event;
    err_nxt    = err_count;
    if (clear) begin
      err_nxt = '0;
    end else if (err_event && (err_count != ERR_MAX)) begin
      err_nxt = err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker: lock, wrap, direction, glitch recovery,
// gaps, asynchronous reset, error saturation and clear.
module tb_count_checker;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_count;
  logic       clear;
  logic       locked;
  logic       dir_up;
  logic       step_err;
  logic [7:0] err_count;
  logic [7:0] expct;

  int total = 0;
  int bad   = 0;

  count_checker #(.WIDTH(8), .ERR_CNT_W(8), .LOCK_N(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_count  (in_count),
    .clear     (clear),
    .locked    (locked),
    .dir_up    (dir_up),
    .step_err  (step_err),
    .err_count (err_count),
    .expected  (expct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  task automatic send(input logic [7:0] v);
    in_valid = 1'b1;
    in_count = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clear(input logic [7:0] v);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_count = v;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
  endtask

  logic [7:0] p;

  initial begin
    reset    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_count = 8'd0;
    #12;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst_locked", locked, 0);
    chk("rst_dir_up", dir_up, 1);
    chk("rst_step_err", step_err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_expected", expct, 1);

    // up stream 0..5
    send(8'd0);
    chk("up_s0_locked", locked, 0);
    send(8'd1);
    chk("up_s1_locked", locked, 0);
    send(8'd2);
    chk("up_s2_locked", locked, 1);
    chk("up_s2_dir", dir_up, 1);
    send(8'd3);
    chk("up_s3_step_err", step_err, 0);
    send(8'd4);
    send(8'd5);
    chk("up_s5_locked", locked, 1);
    chk("up_s5_step_err", step_err, 0);
    chk("up_s5_err_count", err_count, 0);
    chk("up_s5_expected", expct, 6);

    // clear holds prev/dir_up and ignores its sample
    do_clear(8'd99);
    chk("clr1_locked", locked, 0);
    chk("clr1_expected", expct, 6);

    // wrap 255 -> 0 while locked up
    send(8'd250);
    send(8'd251);
    send(8'd252);
    chk("wrap_pre_locked", locked, 1);
    send(8'd253);
    send(8'd254);
    send(8'd255);
    send(8'd0);
    chk("wrap_0_step_err", step_err, 0);
    chk("wrap_0_locked", locked, 1);
    send(8'd1);
    chk("wrap_1_locked", locked, 1);
    chk("wrap_1_expected", expct, 2);
    chk("wrap_err_count", err_count, 0);

    // down stream 3,2,1,0,255,254
    do_clear(8'd40);
    send(8'd3);
    send(8'd2);
    chk("dn_2_dir", dir_up, 0);
    chk("dn_2_locked", locked, 0);
    send(8'd1);
    chk("dn_1_locked", locked, 1);
    send(8'd0);
    send(8'd255);
    chk("dn_255_step_err", step_err, 0);
    send(8'd254);
    chk("dn_end_locked", locked, 1);
    chk("dn_end_dir", dir_up, 0);
    chk("dn_end_expected", expct, 253);
    chk("dn_end_err_count", err_count, 0);

    // gap in in_valid keeps lock and expected
    idle(3);
    chk("gap_locked", locked, 1);
    chk("gap_expected", expct, 253);
    send(8'd253);
    chk("gap_resume_step_err", step_err, 0);
    chk("gap_resume_locked", locked, 1);

    // glitch 10,11,12,14,15,16
    do_clear(8'd7);
    send(8'd10);
    send(8'd11);
    send(8'd12);
    chk("gl_12_locked", locked, 1);
    send(8'd14);
    chk("gl_14_step_err", step_err, 1);
    chk("gl_14_err_count", err_count, 1);
    chk("gl_14_locked", locked, 0);
    send(8'd15);
    chk("gl_15_step_err", step_err, 0);
    chk("gl_15_locked", locked, 0);
    send(8'd16);
    chk("gl_16_locked", locked, 1);
    chk("gl_16_err_count", err_count, 1);

    // reversal while locked is an error, then lock downward
    send(8'd15);
    chk("rev_step_err", step_err, 1);
    chk("rev_err_count", err_count, 2);
    send(8'd14);
    chk("rev_dir", dir_up, 0);
    send(8'd13);
    chk("rev_locked", locked, 1);

    // asynchronous reset between edges
    idle(1);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_step_err", step_err, 0);
    chk("arst_err_count", err_count, 0);
    chk("arst_dir", dir_up, 1);
    chk("arst_expected", expct, 1);
    @(negedge clk);
    reset = 1'b1;
    send(8'd0);
    send(8'd1);
    chk("arst_relock_s1", locked, 0);
    send(8'd2);
    chk("arst_relock_s2", locked, 1);

    // saturation: error, relock, repeat
    p = 8'd2;
    for (int i = 0; i < 300; i++) begin
      send(p + 8'd5);
      send(p + 8'd6);
      send(p + 8'd7);
      p = p + 8'd7;
      if (i == 9) chk("sat_err_count_10", err_count, 10);
    end
    chk("sat_err_count", err_count, 255);
    chk("sat_locked", locked, 1);

    do_clear(p + 8'd100);
    chk("clr2_locked", locked, 0);
    chk("clr2_err_count", err_count, 0);
    chk("clr2_step_err", step_err, 0);
    chk("clr2_expected", expct, 32'(p + 8'd1));
    send(p + 8'd50);
    chk("clr2_s0_locked", locked, 0);
    send(p + 8'd51);
    send(p + 8'd52);
    chk("clr2_relock", locked, 1);
    chk("clr2_relock_err", err_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_checker.md
# count_checker

Stream checker for free-running counters: samples a counter's output bus and infers the counting direction (up or down). It locks onto a consistent ±1 step and flags every sample that breaks the step, including the sample count. It sits on the consumer side of the up/down counter blocks and serves as an in-design monitor and as a bench scoreboard.

## Interface

Parameters
- WIDTH, 8, width of the observed count bus
- ERR_CNT_W, 8, width of the saturating error counter
- LOCK_N, 2, consecutive same-direction ±1 steps required to lock (range 1..15)

Ports
- clk  input  1  rising-edge clock; single clock domain
- reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately
- in_valid  input  1  in_count is sampled on a rising edge where in_valid=1
- in_count  input  WIDTH  observed counter value
- clear  input  1  synchronous clear to IDLE; zeroes err_count; takes priority over in_valid
- locked  output  1  registered; 1 while in LOCKED
- dir_up  output  1  registered; inferred direction, 1=up, 0=down
- step_err  output  1  registered; one-cycle pulse per bad sample while locked
- err_count  output  ERR_CNT_W  registered; saturating count of step_err pulses
- expected  output  WIDTH  combinational, equal to prev + 1 if dir_up else prev − 1, modulo 2^WIDTH

## Operation

- Internal registers: state (IDLE, SEEN, LOCKED), prev[WIDTH], match_cnt (4 bits).
- All step arithmetic is modulo 2^WIDTH. This makes 255→0 a valid up step and 0→255 a valid down step when WIDTH=8.
- IDLE: on in_valid, prev<=in_count and the state moves to SEEN. No other output changes.
- SEEN: on in_valid, prev<=in_count, then:
  - If in_count==prev+1: when dir_up==1 and match_cnt>0, match_cnt increments. Otherwise dir_up<=1 and match_cnt<=1.
  - If in_count==prev−1: handled symmetrically, with dir_up<=0.
  - Any other value, including in_count==prev, gives match_cnt<=0 and dir_up is unchanged.
  - When the updated match_cnt reaches LOCK_N, the state moves to LOCKED and locked<=1.
- LOCKED: on in_valid, prev<=in_count.
  - If in_count==expected: no action.
  - Otherwise:
    - step_err<=1 for one cycle;
    - err_count increments, saturating at 2^ERR_CNT_W−1;
    - the state moves to SEEN, with match_cnt<=0 and locked<=0.
  - A reversal of direction, or a held value (in_count==prev), is an error.
- in_valid=0: every register holds, and step_err returns to 0.
- clear=1: state<=IDLE, match_cnt<=0, locked<=0, step_err<=0, err_count<=0. prev and dir_up hold. The in_count on that edge is ignored.
- Reset values: state IDLE, prev 0, match_cnt 0, dir_up 1, locked 0, step_err 0, err_count 0. expected therefore reads 1.

## Timing

- Every registered output updates on the same edge that samples the triggering in_count and is visible in the following cycle.
- Latency to lock from IDLE with gap-free valid samples: LOCK_N+1 samples. locked is high after the edge of sample LOCK_N+1.
- step_err is high for exactly the one cycle following the bad sample's edge.
- err_count reflects the error in that same cycle.
- Back-to-back errors are impossible: after an error the state is SEEN, and SEEN never raises step_err.
- expected is combinational from prev and dir_up, so it changes in the cycle after each accepted sample.
- Reset asserted mid-operation clears all registers asynchronously, with no wait for clk. Deassertion is assumed synchronous to clk upstream.
- Gaps in in_valid do not break lock. The next valid sample is compared against the held expected value.

## Test plan

- Up stream 0,1,2,3,4,5 with valid every cycle -> locked=1 after sample 2, dir_up=1, step_err never set, err_count=0.
- Locked up stream 253,254,255,0,1 -> no step_err, locked stays 1, expected=2 after sample 1.
- Down stream 3,2,1,0,255,254 -> dir_up=0, locked after sample 1, no errors, expected=253 at the end.
- Glitch: up stream 10,11,12,14,15,16 -> step_err pulses one cycle after 14, err_count=1, locked=0, then locked=1 again after sample 16.
- Saturation: 300 alternating bad samples with relock between them, ERR_CNT_W=8 -> err_count stops at 255. Then clear=1 with in_valid=1 -> state IDLE, err_count=0, locked=0, and that sample is ignored.
- Reset mid-lock: set reset=0 between clock edges while locked=1 -> locked, step_err and err_count go to 0 and dir_up to 1 immediately. After release, a fresh up stream relocks in LOCK_N+1 samples.
